counter_bus_ctrl: RTL and testbench

- Memory-mapped bus front end sitting directly upstream of the counter unit.
- Decodes CPU writes into the counter load interface: `counter_we`, `counter_val` and `counter_ch`.
- Stretches the load strobe so the slower counter clocks can sample it.
- Synchronises the three counter expiry outputs back into `clk`, latches sticky expiry flags and raises `irq`.
- Provides registered readback of value, control and status.

---
 rtl/counter_ctrl_pkg.sv | 16 +
 rtl/counter_edge_sync.sv | 23 ++
 rtl/counter_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_counter_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: register map, bit positions and FSM encoding shared by the counter bus front end
package counter_ctrl_pkg;
    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;
    localparam int CTRL_CH_LSB  = 0;
    localparam int CTRL_EN_LSB  = 4;
    localparam int CTRL_AUTO    = 8;
    localparam int ST_FLAG_LSB  = 0;
    localparam int ST_BUSY      = 3;
    localparam int ST_OVR       = 4;
    localparam int ST_CHERR     = 5;
    localparam logic [1:0] CH_RESERVED = 2'd3;
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/counter_edge_sync.sv
// counter_edge_sync: multi-flop synchroniser for an asynchronous expiry line plus rising-edge pulse
module counter_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    // shift the raw line through the synchroniser and remember the last synchronised level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/counter_bus_ctrl.sv
// counter_bus_ctrl: bus front end for the counter unit; optional auto reload under COUNTER_AUTO_RELOAD_EN
module counter_bus_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WE_HOLD     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_busy,
    output logic        counter_we,
    output logic [31:0] counter_val,
    output logic [1:0]  counter_ch,
    input  logic [31:0] counter_out,
    input  logic        counter0_out,
    input  logic        counter1_out,
    input  logic        counter2_out,
    output logic        irq
);
    state_t      state;
    logic [3:0]  hold_cnt;
    logic [1:0]  ctrl_ch;
    logic [2:0]  ctrl_en;
    logic        auto_en;
    logic [2:0]  flag;
    logic        ovr;
    logic        cherr;
    logic [2:0]  expiry;
    logic [2:0]  pulse;
    logic        idle;
    logic        wr;
    logic        val_wr;
    logic        st_wr;
    logic        val_go;
    logic        reload_go;
    logic        start;
    logic [31:0] rdata_nxt;

    assign expiry = {counter2_out, counter1_out, counter0_out};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_sync
            counter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (expiry[i]),
                .pulse (pulse[i])
            );
        end
    endgenerate

    // bus decode and readback selection
    always_comb begin
        idle      = state == IDLE;
        wr        = bus_cs && bus_we;
        val_wr    = wr && bus_addr == ADDR_VALUE;
        st_wr     = wr && bus_addr == ADDR_STATUS;
        val_go    = val_wr && idle && ctrl_ch != CH_RESERVED;
        start     = val_go || reload_go;
        rdata_nxt = bus_addr == ADDR_VALUE  ? counter_out :
                    bus_addr == ADDR_CTRL   ? {23'b0, auto_en, 1'b0, ctrl_en, 2'b0, ctrl_ch} :
                    bus_addr == ADDR_STATUS ? {26'b0, cherr, ovr, bus_busy, flag} : 32'b0;
    end

`ifdef COUNTER_AUTO_RELOAD_EN
    logic       reload_pend;
    logic [3:0] pulse_ch;
    assign pulse_ch  = {1'b0, pulse};
    assign reload_go = idle && reload_pend;
    // auto-reload enable bit and a single pending reload; a bus load in the same cycle takes precedence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_en     <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            if (wr && bus_addr == ADDR_CTRL) auto_en <= bus_wdata[CTRL_AUTO];
            if (auto_en && pulse_ch[ctrl_ch]) reload_pend <= 1'b1;
            else if (reload_go && !val_go) reload_pend <= 1'b0;
        end
    end
`else
    assign auto_en   = 1'b0;
    assign reload_go = 1'b0;
`endif

    // load sequencer: latch value/channel, hold the strobe WE_HOLD cycles, then one low gap cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            counter_we  <= 1'b0;
            counter_val <= '0;
            counter_ch  <= '0;
            bus_busy    <= 1'b0;
        end else begin
            bus_busy <= !idle;
            case (state)
                IDLE: if (start) begin
                    state      <= HOLD;
                    hold_cnt   <= '0;
                    counter_we <= 1'b1;
                    if (val_go) begin
                        counter_val <= bus_wdata;
                        counter_ch  <= ctrl_ch;
                    end
                end
                HOLD: if (hold_cnt == 4'(WE_HOLD - 1)) begin
                    state      <= GAP;
                    counter_we <= 1'b0;
                end else hold_cnt <= hold_cnt + 4'd1;
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // control/status registers, sticky flags with set-over-clear, interrupt and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_ch   <= '0;
            ctrl_en   <= '0;
            flag      <= '0;
            ovr       <= 1'b0;
            cherr     <= 1'b0;
            irq       <= 1'b0;
            bus_rdata <= '0;
        end else begin
            if (wr && bus_addr == ADDR_CTRL) begin
                ctrl_ch <= bus_wdata[CTRL_CH_LSB +: 2];
                ctrl_en <= bus_wdata[CTRL_EN_LSB +: 3];
            end
            flag  <= (flag & ~(st_wr ? bus_wdata[ST_FLAG_LSB +: 3] : 3'b0)) | pulse;
            ovr   <= (ovr && !(st_wr && bus_wdata[ST_OVR])) || (val_wr && !idle);
            cherr <= (cherr && !(st_wr && bus_wdata[ST_CHERR])) || (val_wr && idle && ctrl_ch == CH_RESERVED);
            irq   <= |(flag & ctrl_en);
            if (bus_cs && !bus_we) bus_rdata <= rdata_nxt;
        end
    end
endmodule

// File: tb/tb_counter_bus_ctrl.sv
// tb_counter_bus_ctrl: directed plus randomized checks of counter_bus_ctrl against a timeline model
module tb_counter_bus_ctrl;
    localparam int WE_HOLD = 4;
    localparam int SS      = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_cs = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        counter_we;
    logic [31:0] counter_val;
    logic [1:0]  counter_ch;
    logic [31:0] counter_out = '0;
    logic        c0 = 1'b0;
    logic        c1 = 1'b0;
    logic        c2 = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    counter_bus_ctrl #(.WE_HOLD(WE_HOLD), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_cs       (bus_cs),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_busy     (bus_busy),
        .counter_we   (counter_we),
        .counter_val  (counter_val),
        .counter_ch   (counter_ch),
        .counter_out  (counter_out),
        .counter0_out (c0),
        .counter1_out (c1),
        .counter2_out (c2),
        .irq          (irq)
    );

    // model: loads are described by the edge index at which they were accepted
    int          cyc = 0;
    int          le = -100;
    int          evq[$];
    int          we_hi = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_mch = '0;
    logic [1:0]  m_ch = '0;
    logic [2:0]  m_en = '0;
    logic [2:0]  m_flag = '0;
    logic [2:0]  d_prev = '0;
    logic        m_ovr = 1'b0;
    logic        m_cherr = 1'b0;
    logic        m_irq = 1'b0;
    logic        m_auto = 1'b0;
    logic        m_pend = 1'b0;

    function automatic bit sb(int t);
        return t >= le && t <= le + WE_HOLD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        le = -100; evq.delete(); m_val = '0; m_rdata = '0; m_mch = '0; m_ch = '0; m_en = '0;
        m_flag = '0; d_prev = '0; m_ovr = 0; m_cherr = 0; m_irq = 0; m_auto = 0; m_pend = 0;
    endtask

    task automatic tick();
        logic [2:0]  d, sets, oflag, oen;
        logic [1:0]  och;
        logic        oauto, busy1, val_go;
        logic [31:0] rv;
        d = {c2, c1, c0}; oflag = m_flag; oen = m_en; och = m_ch; oauto = m_auto;
        @(posedge clk);
        cyc++;
        busy1 = sb(cyc - 1);
        rv = bus_addr == 2'd0 ? counter_out :
             bus_addr == 2'd1 ? {23'b0, m_auto, 1'b0, m_en, 2'b0, m_ch} :
             bus_addr == 2'd2 ? {26'b0, m_cherr, m_ovr, sb(cyc - 2), m_flag} : 32'b0;
        if (bus_cs && !bus_we) m_rdata = rv;
        val_go = 0;
        if (bus_cs && bus_we)
            case (bus_addr)
                2'd0: if (busy1) m_ovr = 1; else if (och == 2'd3) m_cherr = 1;
                      else begin val_go = 1; le = cyc; m_val = bus_wdata; m_mch = och; end
                2'd1: begin
                    m_ch = bus_wdata[1:0]; m_en = bus_wdata[6:4];
`ifdef COUNTER_AUTO_RELOAD_EN
                    m_auto = bus_wdata[8];
`endif
                end
                2'd2: begin
                    m_flag &= ~bus_wdata[2:0];
                    if (bus_wdata[4]) m_ovr = 0;
                    if (bus_wdata[5]) m_cherr = 0;
                end
                default: ;
            endcase
        sets = '0;
        while (evq.size() > 0 && (evq[0] >> 2) == cyc) begin
            sets[evq[0] & 3] = 1'b1;
            void'(evq.pop_front());
        end
        for (int k = 0; k < 3; k++) if (d[k] && !d_prev[k]) evq.push_back(((cyc + SS) << 2) | k);
        d_prev = d;
        m_flag |= sets;
`ifdef COUNTER_AUTO_RELOAD_EN
        if (!val_go && m_pend && !busy1) begin le = cyc; m_pend = 0; end
        if (oauto && och != 2'd3 && sets[och]) m_pend = 1;
`endif
        m_irq = |(oflag & oen);
        #1;
        if (counter_we) we_hi++;
        chk("counter_we", counter_we, le <= cyc && cyc < le + WE_HOLD);
        chk("bus_busy", bus_busy, sb(cyc - 1));
        chk("irq", irq, m_irq);
        chk("bus_rdata", bus_rdata, m_rdata);
        chk("counter_val", counter_val, m_val);
        chk("counter_ch", counter_ch, m_mch);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] dt);
        bus_cs = 1; bus_we = 1; bus_addr = a; bus_wdata = dt;
        tick();
        bus_cs = 0; bus_we = 0;
    endtask

    task automatic rd(input logic [1:0] a);
        bus_cs = 1; bus_we = 0; bus_addr = a;
        tick();
        bus_cs = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        idle(2);
        chk("rst_we", counter_we, 0);
        chk("rst_rdata", bus_rdata, 0);
        reset = 1;
        idle(1);
        // basic load on channel 1, then overrun during HOLD
        wr(2'd1, 32'h1);
        we_hi = 0;
        wr(2'd0, 32'h100);
        wr(2'd0, 32'hFFFF);
        rd(2'd2);
        chk("status_busy_ovr", bus_rdata, 32'h18);
        chk("val_frozen", counter_val, 32'h100);
        chk("ch_load", counter_ch, 2'd1);
        idle(3);
        chk("busy_at5", bus_busy, 1);
        idle(1);
        chk("busy_at6", bus_busy, 0);
        chk("we_len", we_hi, WE_HOLD);
        wr(2'd2, 32'h10);
        rd(2'd2);
        chk("ovr_cleared", bus_rdata, 32'h0);
        // reserved channel
        wr(2'd1, 32'h3);
        we_hi = 0;
        wr(2'd0, 32'h55);
        idle(6);
        chk("cherr_no_we", we_hi, 0);
        rd(2'd2);
        chk("cherr_status", bus_rdata, 32'h20);
        chk("cherr_busy", bus_busy, 0);
        wr(2'd2, 32'h20);
        // expiry, irq latency, W1C and set-over-clear
        wr(2'd1, 32'h10);
        c0 = 1;
        tick();
        c0 = 0;
        lat = 1;
        while (!irq && lat < 10) begin tick(); lat++; end
        chk("irq_latency", lat, SS + 2);
        wr(2'd2, 32'h1);
        chk("irq_hold", irq, 1);
        tick();
        chk("irq_drop", irq, 0);
        c0 = 1;
        tick();
        c0 = 0;
        tick();
        wr(2'd2, 32'h1);
        tick();
        chk("set_wins_irq", irq, 1);
        rd(2'd2);
        chk("set_wins_flag", bus_rdata, 32'h1);
        // reset in the middle of HOLD
        wr(2'd1, 32'h2);
        wr(2'd0, 32'hABC);
        tick();
        reset = 0;
        #1;
        chk("async_we_drop", counter_we, 0);
        model_reset();
        tick();
        reset = 1;
        tick();
        rd(2'd2);
        chk("post_rst_status", bus_rdata, 32'h0);
        we_hi = 0;
        wr(2'd0, 32'h77);
        idle(6);
        chk("post_rst_load", we_hi, WE_HOLD);
        chk("post_rst_val", counter_val, 32'h77);
`ifdef COUNTER_AUTO_RELOAD_EN
        wr(2'd1, 32'h110);
        wr(2'd0, 32'h20);
        idle(7);
        we_hi = 0;
        c0 = 1;
        tick();
        c0 = 0;
        idle(12);
        chk("auto_we_len", we_hi, WE_HOLD);
        chk("auto_val", counter_val, 32'h20);
        rd(2'd2);
        chk("auto_no_ovr", bus_rdata[4], 0);
`endif
        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            counter_out = $urandom;
            c0 = $urandom_range(0, 3) == 0;
            c1 = $urandom_range(0, 3) == 0;
            c2 = $urandom_range(0, 3) == 0;
            case (r)
                0, 1: wr(2'd1, $urandom);
                2, 3: wr(2'd0, $urandom);
                4: wr(2'd2, $urandom);
                5, 6: rd(2'($urandom_range(0, 3)));
                7: wr(2'd3, $urandom);
                default: tick();
            endcase
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
